// File: rtl/bitnet_pkg.sv
// Shared types and elaboration helpers for the bitnet downsampling layers.
package bitnet_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FWD  = 2'd1,
        BWD  = 2'd2,
        DONE = 2'd3
    } state_t;

    function automatic int ceil_div(input int a, input int b);
        return (a + b - 1) / b;
    endfunction

    // Constant filler for the tail of the last group, alternating from the top bit down.
    function automatic logic pad_bit(input int p, input int padding);
        return ((padding - 1 - p) % 2) == 1;
    endfunction

endpackage

// File: rtl/downk_layer_if.sv
// Request/response bundle between a controller and the downk_layer datapath.
interface downk_layer_if #(
    parameter int N      = 27,
    parameter int FAN_IN = 3
);
    import bitnet_pkg::*;

    localparam int OUT_N = ceil_div(N, FAN_IN);

    logic                      oscillator;
    logic                      learn_en;
    logic                      fd_prop;
    logic                      bk_prop;
    logic [N-1:0]              fin;
    logic [OUT_N-1:0]          bin;
    logic [OUT_N-1:0]          fout;
    logic [N-1:0]              bout;
    logic [OUT_N*FAN_IN-1:0]   weights_out;
    logic                      busy;
    logic                      fd_prop_done;
    logic                      bk_prop_done;
    logic                      collision;

    modport master (
        output oscillator, learn_en, fd_prop, bk_prop, fin, bin,
        input  fout, bout, weights_out, busy, fd_prop_done, bk_prop_done, collision
    );

    modport slave (
        input  oscillator, learn_en, fd_prop, bk_prop, fin, bin,
        output fout, bout, weights_out, busy, fd_prop_done, bk_prop_done, collision
    );

endinterface

// File: rtl/downk_lane.sv
// One reduction lane: weighted majority forward, per-input error and next weights backward.
module downk_lane #(
    parameter int FAN_IN = 3
) (
    input  logic [FAN_IN-1:0] x,
    input  logic [FAN_IN-1:0] w,
    input  logic              b,
    output logic              maj,
    output logic [FAN_IN-1:0] bout,
    output logic [FAN_IN-1:0] w_next
);
    localparam int CW = $clog2(FAN_IN + 1);

    function automatic logic [CW-1:0] popcount(input logic [FAN_IN-1:0] v);
        logic [CW-1:0] c;
        c = '0;
        for (int j = 0; j < FAN_IN; j++) begin
            c = c + CW'(v[j]);
        end
        return c;
    endfunction

    logic [CW-1:0] cnt;

    assign cnt = popcount(x ~^ w);
    // Doubling the count keeps the even-FAN_IN tie resolving to 1 without division.
    assign maj    = ({cnt, 1'b0} >= (CW + 1)'(FAN_IN));
    assign bout   = {FAN_IN{b}} ~^ w;
    assign w_next = x ~^ {FAN_IN{b}};

endmodule

// File: rtl/downk_layer.sv
// Time-multiplexed FAN_IN-to-1 binary majority layer with backward error and stochastic learning.
module downk_layer
    import bitnet_pkg::*;
#(
    parameter int N      = 27,
    parameter int FAN_IN = 3,
    parameter int LANES  = 1
) (
    input logic         clk_in,
    input logic         rst_in,
    downk_layer_if.slave bus
);
    localparam int OUT_N    = ceil_div(N, FAN_IN);
    localparam int PADDED_N = OUT_N * FAN_IN;
    localparam int PADDING  = PADDED_N - N;
    localparam int PASSES   = ceil_div(OUT_N, LANES);
    localparam int KW       = (PASSES > 1) ? $clog2(PASSES) : 1;

    state_t                state;
    logic [KW-1:0]         k;
    logic                  op_bwd;
    logic                  learn_lat;
    logic [PADDED_N-1:0]   fin_lat;
    logic [OUT_N-1:0]      bin_lat;
    logic [PADDED_N-1:0]   w;
    logic [OUT_N-1:0]      fout_reg;
    logic [N-1:0]          bout_reg;
    logic                  fd_done;
    logic                  bk_done;
    logic                  coll;

    logic [PADDED_N-1:0]     fin_pad;
    logic [31:0]             grp_base;
    logic [LANES-1:0]        lane_maj;
    logic [LANES*FAN_IN-1:0] lane_bout;
    logic [LANES*FAN_IN-1:0] lane_wn;

    always_comb begin
        fin_pad = '0;
        fin_pad[N-1:0] = bus.fin;
        for (int p = 0; p < PADDING; p++) begin
            fin_pad[N+p] = pad_bit(p, PADDING);
        end
    end

    assign grp_base = 32'(k) * 32'(LANES);

    // Lanes past the last group shift in zeros; the write-back loops never select them.
    for (genvar l = 0; l < LANES; l++) begin : g_lane
        logic [31:0] sh;
        assign sh = (grp_base + 32'(l)) * 32'(FAN_IN);

        downk_lane #(.FAN_IN(FAN_IN)) u_lane (
            .x      (FAN_IN'(fin_lat >> sh)),
            .w      (FAN_IN'(w >> sh)),
            .b      (1'(bin_lat >> (grp_base + 32'(l)))),
            .maj    (lane_maj[l]),
            .bout   (lane_bout[l*FAN_IN +: FAN_IN]),
            .w_next (lane_wn[l*FAN_IN +: FAN_IN])
        );
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state     <= IDLE;
            k         <= '0;
            op_bwd    <= 1'b0;
            learn_lat <= 1'b0;
            fin_lat   <= '0;
            bin_lat   <= '0;
            w         <= '1;
            fout_reg  <= '0;
            bout_reg  <= '0;
            fd_done   <= 1'b0;
            bk_done   <= 1'b0;
            coll      <= 1'b0;
        end else begin
            fd_done <= 1'b0;
            bk_done <= 1'b0;
            coll    <= (state != IDLE) ? (bus.fd_prop | bus.bk_prop)
                                       : (bus.fd_prop & bus.bk_prop);
            case (state)
                IDLE: begin
                    k <= '0;
                    if (bus.fd_prop) begin
                        fin_lat <= fin_pad;
                        op_bwd  <= 1'b0;
                        state   <= FWD;
                    end else if (bus.bk_prop) begin
                        bin_lat   <= bus.bin;
                        learn_lat <= bus.learn_en;
                        op_bwd    <= 1'b1;
                        state     <= BWD;
                    end
                end
                FWD: begin
                    for (int i = 0; i < OUT_N; i++) begin
                        if (k == KW'(i / LANES)) fout_reg[i] <= lane_maj[i % LANES];
                    end
                    if (k == KW'(PASSES - 1)) state <= DONE;
                    else                      k     <= k + 1'b1;
                end
                BWD: begin
                    for (int i = 0; i < N; i++) begin
                        if (k == KW'((i / FAN_IN) / LANES))
                            bout_reg[i] <= lane_bout[((i / FAN_IN) % LANES) * FAN_IN + (i % FAN_IN)];
                    end
                    if (learn_lat && bus.oscillator) begin
                        for (int i = 0; i < PADDED_N; i++) begin
                            if (k == KW'((i / FAN_IN) / LANES))
                                w[i] <= lane_wn[((i / FAN_IN) % LANES) * FAN_IN + (i % FAN_IN)];
                        end
                    end
                    if (k == KW'(PASSES - 1)) state <= DONE;
                    else                      k     <= k + 1'b1;
                end
                DONE: begin
                    fd_done <= ~op_bwd;
                    bk_done <= op_bwd;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.fout         = fout_reg;
    assign bus.bout         = bout_reg;
    assign bus.weights_out  = w;
    assign bus.busy         = (state != IDLE);
    assign bus.fd_prop_done = fd_done;
    assign bus.bk_prop_done = bk_done;
    assign bus.collision    = coll;

endmodule

// File: tb/tb_downk_layer.sv
// Directed scoreboard bench for downk_layer across three geometries.
module tb_downk_layer;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    downk_layer_if #(.N(7),  .FAN_IN(3)) if7 ();
    downk_layer_if #(.N(27), .FAN_IN(3)) if27 ();
    downk_layer_if #(.N(8),  .FAN_IN(4)) if8 ();

    downk_layer #(.N(7),  .FAN_IN(3), .LANES(1)) u7  (.clk_in(clk), .rst_in(rst), .bus(if7));
    downk_layer #(.N(27), .FAN_IN(3), .LANES(2)) u27 (.clk_in(clk), .rst_in(rst), .bus(if27));
    downk_layer #(.N(8),  .FAN_IN(4), .LANES(1)) u8  (.clk_in(clk), .rst_in(rst), .bus(if8));

    int total = 0;
    int bad   = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mw7, mfl7, mw27, mfl27, mw8, mfl8, mbout7, pad;
    int lat, lat2, ncoll, cnt;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [63:0] m_pad(input logic [63:0] fin, input int n, input int fi);
        int on, pd;
        logic [63:0] r;
        on = (n + fi - 1) / fi;
        pd = on * fi - n;
        r = fin & ((64'd1 << n) - 64'd1);
        for (int p = 0; p < pd; p++) r[n+p] = ((pd - 1 - p) % 2) == 1;
        return r;
    endfunction

    function automatic logic [63:0] m_fwd(input logic [63:0] pv, input logic [63:0] wv,
                                          input int n, input int fi);
        int on, c;
        logic [63:0] r;
        on = (n + fi - 1) / fi;
        r = '0;
        for (int g = 0; g < on; g++) begin
            c = 0;
            for (int j = 0; j < fi; j++) if (pv[g*fi+j] == wv[g*fi+j]) c++;
            r[g] = (2 * c >= fi);
        end
        return r;
    endfunction

    function automatic logic [63:0] m_bwd(input logic [63:0] bv, input logic [63:0] wv,
                                          input int n, input int fi);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < n; i++) r[i] = (bv[i/fi] == wv[i]);
        return r;
    endfunction

    function automatic logic [63:0] m_upd(input logic [63:0] fl, input logic [63:0] bv,
                                          input int n, input int fi);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < ((n + fi - 1) / fi) * fi; i++) r[i] = (fl[i] == bv[i/fi]);
        return r;
    endfunction

    function automatic logic done_of(input int sel, input bit bk);
        case (sel)
            0:       return bk ? if7.bk_prop_done  : if7.fd_prop_done;
            1:       return bk ? if27.bk_prop_done : if27.fd_prop_done;
            default: return bk ? if8.bk_prop_done  : if8.fd_prop_done;
        endcase
    endfunction

    function automatic logic coll_of(input int sel);
        case (sel)
            0:       return if7.collision;
            1:       return if27.collision;
            default: return if8.collision;
        endcase
    endfunction

    task automatic set_req(input int sel, input bit fd, input bit bk);
        case (sel)
            0:       begin if7.fd_prop  = fd; if7.bk_prop  = bk; end
            1:       begin if27.fd_prop = fd; if27.bk_prop = bk; end
            default: begin if8.fd_prop  = fd; if8.bk_prop  = bk; end
        endcase
    endtask

    // Ends on the falling edge right after the request edge (cycle 0).
    task automatic pulse(input int sel, input bit fd, input bit bk);
        @(negedge clk);
        set_req(sel, fd, bk);
        @(negedge clk);
        set_req(sel, 1'b0, 1'b0);
    endtask

    task automatic wait_done(input int sel, input bit bk, output int l, output int nc);
        l = 0;
        nc = 0;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (coll_of(sel)) nc++;
            if (done_of(sel, bk)) begin
                l = c;
                break;
            end
        end
    endtask

    initial begin
        if7.oscillator = 0;  if7.learn_en = 0;  if7.fd_prop = 0;  if7.bk_prop = 0;  if7.fin = '0;  if7.bin = '0;
        if27.oscillator = 0; if27.learn_en = 0; if27.fd_prop = 0; if27.bk_prop = 0; if27.fin = '0; if27.bin = '0;
        if8.oscillator = 0;  if8.learn_en = 0;  if8.fd_prop = 0;  if8.bk_prop = 0;  if8.fin = '0;  if8.bin = '0;
        mw7 = 64'h1FF; mfl7 = '0; mbout7 = '0;
        mw27 = (64'd1 << 27) - 64'd1; mfl27 = '0;
        mw8 = 64'hFF; mfl8 = '0;

        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_weights", if7.weights_out, 64'h1FF);
        check("rst_fout", if7.fout, 64'd0);
        check("rst_bout", if7.bout, 64'd0);
        check("rst_busy", if7.busy, 64'd0);
        check("rst_coll", if7.collision, 64'd0);

        // Forward with padded tail 01
        if7.fin = 7'b1011001;
        pad = m_pad(64'(if7.fin), 7, 3);
        exp_q.push_back(m_fwd(pad, mw7, 7, 3));
        pulse(0, 1'b1, 1'b0);
        mfl7 = pad;
        check("fwd1_busy", if7.busy, 64'd1);
        wait_done(0, 1'b0, lat, ncoll);
        check("fwd1_lat", lat, 64'd4);
        check("fwd1_fout", if7.fout, exp_q.pop_front());
        check("fwd1_const", if7.fout, 64'b110);

        // Backward without learning
        if7.bin = 3'b101; if7.learn_en = 0;
        exp_q.push_back(m_bwd(64'(if7.bin), mw7, 7, 3));
        pulse(0, 1'b0, 1'b1);
        wait_done(0, 1'b1, lat, ncoll);
        check("bwd1_lat", lat, 64'd4);
        check("bwd1_bout", if7.bout, exp_q.pop_front());
        check("bwd1_const", if7.bout, 64'b1000111);
        check("bwd1_w", if7.weights_out, mw7);
        check("bwd1_fout_kept", if7.fout, 64'b110);

        // Backward with learning, oscillator high
        if7.learn_en = 1; if7.oscillator = 1;
        exp_q.push_back(m_bwd(64'(if7.bin), mw7, 7, 3));
        mw7 = m_upd(mfl7, 64'(if7.bin), 7, 3);
        pulse(0, 1'b0, 1'b1);
        wait_done(0, 1'b1, lat, ncoll);
        check("bwd2_bout", if7.bout, exp_q.pop_front());
        check("bwd2_const", if7.bout, 64'b1000111);
        check("bwd2_w", if7.weights_out, mw7);
        check("bwd2_wconst", if7.weights_out, 64'h0E1);

        exp_q.push_back(m_fwd(mfl7, mw7, 7, 3));
        pulse(0, 1'b1, 1'b0);
        wait_done(0, 1'b0, lat, ncoll);
        check("fwd2_fout", if7.fout, exp_q.pop_front());
        check("fwd2_const", if7.fout, 64'b101);

        // Learning enabled but oscillator low: weights hold
        if7.oscillator = 0;
        mbout7 = m_bwd(64'(if7.bin), mw7, 7, 3);
        exp_q.push_back(mbout7);
        pulse(0, 1'b0, 1'b1);
        wait_done(0, 1'b1, lat, ncoll);
        check("bwd3_bout", if7.bout, exp_q.pop_front());
        check("bwd3_w", if7.weights_out, mw7);

        // Simultaneous requests in IDLE: forward wins
        if7.fin = 7'b0100110; if7.bin = 3'b010; if7.learn_en = 0;
        pad = m_pad(64'(if7.fin), 7, 3);
        exp_q.push_back(m_fwd(pad, mw7, 7, 3));
        pulse(0, 1'b1, 1'b1);
        mfl7 = pad;
        check("coll_both", if7.collision, 64'd1);
        wait_done(0, 1'b0, lat, ncoll);
        check("coll_both_lat", lat, 64'd4);
        check("coll_both_extra", ncoll, 64'd0);
        check("coll_both_fout", if7.fout, exp_q.pop_front());
        check("coll_both_bout", if7.bout, mbout7);
        cnt = 0;
        repeat (6) begin @(negedge clk); if (if7.bk_prop_done) cnt++; end
        check("coll_both_nobk", cnt, 64'd0);

        // Request while busy is dropped
        if7.fin = 7'b1110001;
        pad = m_pad(64'(if7.fin), 7, 3);
        exp_q.push_back(m_fwd(pad, mw7, 7, 3));
        pulse(0, 1'b1, 1'b0);
        mfl7 = pad;
        @(negedge clk);
        if7.fd_prop = 1; if7.fin = 7'b0000000;
        @(negedge clk);
        if7.fd_prop = 0;
        check("coll_busy", if7.collision, 64'd1);
        wait_done(0, 1'b0, lat2, ncoll);
        check("coll_busy_lat", lat2 + 2, 64'd4);
        check("coll_busy_fout", if7.fout, exp_q.pop_front());

        // Asynchronous reset in the middle of a forward
        if7.fin = 7'b0101010;
        pulse(0, 1'b1, 1'b0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_busy", if7.busy, 64'd0);
        check("mid_rst_fout", if7.fout, 64'd0);
        check("mid_rst_w", if7.weights_out, 64'h1FF);
        mw7 = 64'h1FF; mfl7 = '0;
        @(negedge clk);
        rst = 1'b0;
        cnt = 0;
        repeat (8) begin @(negedge clk); if (if7.fd_prop_done) cnt++; end
        check("mid_rst_nodone", cnt, 64'd0);

        // Backward learning before any forward uses zero inputs
        if7.bin = 3'b011; if7.learn_en = 1; if7.oscillator = 1;
        exp_q.push_back(m_bwd(64'(if7.bin), mw7, 7, 3));
        mw7 = m_upd(mfl7, 64'(if7.bin), 7, 3);
        pulse(0, 1'b0, 1'b1);
        wait_done(0, 1'b1, lat, ncoll);
        check("bwd0_bout", if7.bout, exp_q.pop_front());
        check("bwd0_w", if7.weights_out, mw7);
        check("bwd0_wconst", if7.weights_out, 64'h1C0);

        // Two lanes, five passes
        if27.fin = 27'h5A5A5A5;
        pad = m_pad(64'(if27.fin), 27, 3);
        exp_q.push_back(m_fwd(pad, mw27, 27, 3));
        pulse(1, 1'b1, 1'b0);
        mfl27 = pad;
        wait_done(1, 1'b0, lat, ncoll);
        check("l2_fwd_lat", lat, 64'd6);
        check("l2_fwd_fout", if27.fout, exp_q.pop_front());

        if27.bin = 9'h1A5; if27.learn_en = 1; if27.oscillator = 1;
        exp_q.push_back(m_bwd(64'(if27.bin), mw27, 27, 3));
        mw27 = m_upd(mfl27, 64'(if27.bin), 27, 3);
        pulse(1, 1'b0, 1'b1);
        wait_done(1, 1'b1, lat, ncoll);
        check("l2_bwd_lat", lat, 64'd6);
        check("l2_bwd_bout", if27.bout, exp_q.pop_front());
        check("l2_bwd_w", if27.weights_out, mw27);

        // Even fan-in tie resolves to 1
        if8.fin = 8'b0011_0001;
        pad = m_pad(64'(if8.fin), 8, 4);
        exp_q.push_back(m_fwd(pad, mw8, 8, 4));
        pulse(2, 1'b1, 1'b0);
        mfl8 = pad;
        wait_done(2, 1'b0, lat, ncoll);
        check("f4_lat", lat, 64'd3);
        check("f4_fout", if8.fout, exp_q.pop_front());
        check("f4_const", if8.fout, 64'b10);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/downk_layer.md
Name: downk_layer

Overview:
- Parametrised successor to the fixed 3-to-1 downsampling layer in the bitnet datapath.
- Each group of FAN_IN input bits reduces to one output bit by binary-weighted majority (XNOR with a stored weight, then majority vote).
- Backward propagation returns per-input error bits and optionally applies a stochastic, oscillator-gated weight update.
- A group is computed by one of LANES physical lanes, time-multiplexed over the groups, with an FSM and done pulses in place of a fixed-delay done.

Parameters:
- N, 27: input vector width.
- FAN_IN, 3: inputs per output (≥2).
- LANES, 1: physical lanes; 1 ≤ LANES ≤ OUT_N.
- Derived, not overridable:
  - OUT_N = ceil(N/FAN_IN)
  - PADDED_N = OUT_N*FAN_IN
  - PADDING = PADDED_N−N
  - PASSES = ceil(OUT_N/LANES)

Ports:
- clk_in  in  1  clock.
- rst_in  in  1  reset, asynchronous, active-high.
- oscillator  in  1  stochastic update gate, sampled each BWD cycle.
- learn_en  in  1  enables weight update during backward; sampled with bk_prop.
- fd_prop  in  1  start-forward request, single-cycle pulse.
- bk_prop  in  1  start-backward request, single-cycle pulse.
- fin  in  N  forward input vector.
- bin  in  OUT_N  backward error vector.
- fout  out  OUT_N  forward result, registered.
- bout  out  N  backward result, registered.
- weights_out  out  OUT_N*FAN_IN  current weights; bit g*FAN_IN+j = w[g][j].
- busy  out  1  high in FWD/BWD/DONE.
- fd_prop_done  out  1  one-cycle pulse when fout is complete.
- bk_prop_done  out  1  one-cycle pulse when bout and weights are complete.
- collision  out  1  one-cycle pulse when a request is dropped.

Behaviour:
- Reset (async, any state):
  - FSM→IDLE.
  - fout, bout, the done pulses and collision all 0.
  - All weights 1 (identity).
  - Latched fin/bin cleared; pass counter 0.
- Padding: padded bit N+p (0≤p<PADDING) = (PADDING−1−p) mod 2. Examples: PADDING=2 gives bits {N+1:N}=01; PADDING=1 gives 0. Padding is constant, never weighted away.
- Forward, group g:
  - x_j = padded[g*FAN_IN+j] XNOR w[g][j].
  - fout[g] = 1 iff 2*popcount(x) ≥ FAN_IN, so an even-FAN_IN tie gives 1.
  - Popcount width is clog2(FAN_IN+1).
- Backward, group g:
  - bout[g*FAN_IN+j] = bin[g] XNOR w_old[g][j], using the weight before this pass's update. Padded positions are discarded.
  - Update applies only when learn_en was latched and oscillator=1 on that pass cycle: w[g][j] ← fin_lat[padded idx] XNOR bin[g], where fin_lat is the padded input latched by the last forward.
- FSM: IDLE→FWD/BWD→DONE→IDLE.
  - IDLE: on fd_prop, latch fin and go to FWD. Otherwise, on bk_prop, latch bin and learn_en and go to BWD.
  - FWD/BWD: pass counter k=0..PASSES−1, one pass per cycle. Lane l handles group k*LANES+l; lanes with group ≥OUT_N are inactive and write nothing. After pass PASSES−1, go to DONE.
  - DONE: pulse the matching *_done for one cycle, then return to IDLE.
- Latency: request at cycle 0; *_done high at cycle PASSES+1. fout/bout are stable from that cycle until the next operation of the same kind.
- Untouched outputs: fout is not modified by backward; bout is not modified by forward.
- Collisions:
  - fd_prop and bk_prop together in IDLE: forward wins, bk dropped, collision pulses.
  - Any request while busy: dropped, collision pulses, operation in flight unaffected.
- Backward before any forward since reset uses fin_lat=0.

Decomposition:
- bitnet_pkg holds:
  - ceil_div function;
  - pad_bit(p, padding) function;
  - FSM state enum {IDLE, FWD, BWD, DONE}.
- One sub-module, downk_lane: combinational, FAN_IN inputs + FAN_IN weights + bin bit → majority bit, FAN_IN bout bits, FAN_IN next-weight bits.
- The top level holds the FSM, pass counter, latches, weight array and lane muxing.

Test Plan:
1. Reset, N=7, FAN_IN=3, LANES=1 (PASSES=3):
   - weights_out=9'h1FF; fout=0, bout=0; busy=0.
   - fd_prop with fin=7'b1011001 (padded bits 8:7=01) → fout=3'b110, fd_prop_done at cycle 4 exactly.
2. Then bk_prop, bin=3'b101, learn_en=0 → bout=7'b1000111, weights unchanged, bk_prop_done at cycle 4.
3. bk_prop, bin=3'b101, learn_en=1, oscillator=1 → bout=7'b1000111.
   - weights w0=3'b001, w1=3'b100, w2=3'b011.
   - Re-forward the same fin → fout=3'b101.
   - Repeat with oscillator=0 → weights unchanged.
4. Collisions:
   - fd_prop and bk_prop in the same IDLE cycle → forward only, one collision pulse.
   - fd_prop in FWD cycle 2 → second collision pulse, done still at cycle 4, fout unchanged.
5. Assert rst_in mid-FWD (pass 1) → immediately IDLE, fout=0, weights all 1, no fd_prop_done.
6. N=27, FAN_IN=3, LANES=2 (PASSES=5):
   - fin=27'h5A5A5A5 → fout equals the model, fd_prop_done at cycle 6, lane 1 idle on the last pass.
   - N=8, FAN_IN=4, fin=8'b0011_0001 → fout=2'b10 (tie gives 1).
